uart_rx_dma: RTL and testbench

Bus-master controller that moves received bytes from the two UART receivers into per-UART ring buffers in data memory. It takes the memory bus only when the CPU is neither reading nor writing, and alternates fairly between the two UARTs. It drains each UART's ready/ack handshake and exposes write pointers and wrap flags so software can poll the buffers.

---
 rtl/uart_rx_dma.sv | 134 +++++++++++++
 tb/tb_uart_rx_dma.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_dma.sv
// uart_rx_dma: moves received bytes from two UART receivers into
// per-UART ring buffers in data memory. The memory bus is taken only
// when the CPU is idle, and the two UARTs are served round-robin.
module uart_rx_dma #(
  parameter logic [31:0] BASE0 = 32'h0000_0100,
  parameter logic [31:0] BASE1 = 32'h0000_0200,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned PW    = 4
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          memReadCPU,
  input  logic          memWriteCPU,
  input  logic          readyRx0,
  input  logic [7:0]    rxData0,
  input  logic          readyRx1,
  input  logic [7:0]    rxData1,
  input  logic          clr0,
  input  logic          clr1,
  output logic          busGrant,
  output logic          memWriteOut,
  output logic [31:0]   memAddress,
  output logic [7:0]    memData,
  output logic          ackRx0,
  output logic          ackRx1,
  output logic [PW-1:0] wrPtr0,
  output logic [PW-1:0] wrPtr1,
  output logic          wrap0,
  output logic          wrap1
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GRANT = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;

  logic [1:0]    state_q, state_d;
  logic          sel_q, sel_d;
  logic          last_q, last_d;
  logic [31:0]   memAddress_q, memAddress_d;
  logic [7:0]    memData_q, memData_d;
  logic [PW-1:0] wrPtr0_q, wrPtr0_d;
  logic [PW-1:0] wrPtr1_q, wrPtr1_d;
  logic          wrap0_q, wrap0_d;
  logic          wrap1_q, wrap1_d;

  logic bus_free;
  logic pick;

  assign bus_free = !memReadCPU && !memWriteCPU;
  // Single requester wins outright; on a tie, serve the channel not served last.
  assign pick = (readyRx0 && readyRx1) ? ~last_q : readyRx1;

  // Next-state logic: channel selection, latching, pointer advance and clears.
  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    last_d       = last_q;
    memAddress_d = memAddress_q;
    memData_d    = memData_q;
    wrPtr0_d     = wrPtr0_q;
    wrPtr1_d     = wrPtr1_q;
    wrap0_d      = wrap0_q;
    wrap1_d      = wrap1_q;
    case (state_q)
      IDLE: begin
        if (bus_free && (readyRx0 || readyRx1)) begin
          sel_d        = pick;
          memData_d    = pick ? rxData1 : rxData0;
          memAddress_d = pick ? (BASE1 + 32'(wrPtr1_q)) : (BASE0 + 32'(wrPtr0_q));
          state_d      = GRANT;
        end
      end
      GRANT: state_d = WRITE;
      WRITE: begin
        if (sel_q) begin
          wrPtr1_d = wrPtr1_q + PW'(1);
          if (&wrPtr1_q) wrap1_d = 1'b1;
        end else begin
          wrPtr0_d = wrPtr0_q + PW'(1);
          if (&wrPtr0_q) wrap0_d = 1'b1;
        end
        last_d  = sel_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // A clear overrides a coincident pointer advance on the same channel.
    if (clr0) begin
      wrPtr0_d = '0;
      wrap0_d  = 1'b0;
    end
    if (clr1) begin
      wrPtr1_d = '0;
      wrap1_d  = 1'b0;
    end
  end

  // State registers with synchronous reset; reset aborts any transfer unacked.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      sel_q        <= 1'b0;
      last_q       <= 1'b1;
      memAddress_q <= '0;
      memData_q    <= '0;
      wrPtr0_q     <= '0;
      wrPtr1_q     <= '0;
      wrap0_q      <= 1'b0;
      wrap1_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      last_q       <= last_d;
      memAddress_q <= memAddress_d;
      memData_q    <= memData_d;
      wrPtr0_q     <= wrPtr0_d;
      wrPtr1_q     <= wrPtr1_d;
      wrap0_q      <= wrap0_d;
      wrap1_q      <= wrap1_d;
    end
  end

  assign busGrant    = (state_q == GRANT) || (state_q == WRITE);
  assign memWriteOut = (state_q == WRITE);
  assign ackRx0      = (state_q == WRITE) && !sel_q;
  assign ackRx1      = (state_q == WRITE) && sel_q;
  assign memAddress  = memAddress_q;
  assign memData     = memData_q;
  assign wrPtr0      = wrPtr0_q;
  assign wrPtr1      = wrPtr1_q;
  assign wrap0       = wrap0_q;
  assign wrap1       = wrap1_q;

endmodule

// File: tb/tb_uart_rx_dma.sv
// Directed testbench for uart_rx_dma with hand-computed expectations.
module tb_uart_rx_dma;

  logic        clock = 1'b0;
  logic        reset;
  logic        memReadCPU, memWriteCPU;
  logic        readyRx0, readyRx1;
  logic [7:0]  rxData0, rxData1;
  logic        clr0, clr1;
  logic        busGrant, memWriteOut, ackRx0, ackRx1;
  logic [31:0] memAddress;
  logic [7:0]  memData;
  logic [3:0]  wrPtr0, wrPtr1;
  logic        wrap0, wrap1;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  uart_rx_dma #(
    .BASE0(32'h0000_0100),
    .BASE1(32'h0000_0200),
    .DEPTH(16),
    .PW(4)
  ) dut (
    .clock(clock), .reset(reset),
    .memReadCPU(memReadCPU), .memWriteCPU(memWriteCPU),
    .readyRx0(readyRx0), .rxData0(rxData0),
    .readyRx1(readyRx1), .rxData1(rxData1),
    .clr0(clr0), .clr1(clr1),
    .busGrant(busGrant), .memWriteOut(memWriteOut),
    .memAddress(memAddress), .memData(memData),
    .ackRx0(ackRx0), .ackRx1(ackRx1),
    .wrPtr0(wrPtr0), .wrPtr1(wrPtr1),
    .wrap0(wrap0), .wrap1(wrap1)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_grant", 32'(busGrant), 0);
    chk("rst_wr", 32'(memWriteOut), 0);
    chk("rst_ack", {30'd0, ackRx1, ackRx0}, 0);
    chk("rst_addr", memAddress, 0);
    chk("rst_data", 32'(memData), 0);
    chk("rst_ptrs", {24'd0, wrPtr1, wrPtr0}, 0);
    chk("rst_wraps", {30'd0, wrap1, wrap0}, 0);
  endtask

  // One full transfer on channel ch from a bus-free IDLE state.
  task automatic do_byte(input logic ch, input logic [7:0] d, input logic [31:0] addr);
    if (ch) begin readyRx1 = 1'b1; rxData1 = d; end
    else    begin readyRx0 = 1'b1; rxData0 = d; end
    tick();
    chk("g_grant", 32'(busGrant), 1);
    chk("g_wr", 32'(memWriteOut), 0);
    chk("g_ack", {30'd0, ackRx1, ackRx0}, 0);
    tick();
    chk("w_grant", 32'(busGrant), 1);
    chk("w_wr", 32'(memWriteOut), 1);
    chk("w_addr", memAddress, addr);
    chk("w_data", 32'(memData), 32'(d));
    chk("w_ack", {30'd0, ackRx1, ackRx0}, ch ? 2 : 1);
    if (ch) readyRx1 = 1'b0; else readyRx0 = 1'b0;
    tick();
    chk("i_grant", 32'(busGrant), 0);
    chk("i_ack", {30'd0, ackRx1, ackRx0}, 0);
  endtask

  initial begin
    reset = 1'b1; memReadCPU = 0; memWriteCPU = 0;
    readyRx0 = 0; readyRx1 = 0; rxData0 = 0; rxData1 = 0; clr0 = 0; clr1 = 0;
    do_reset();

    // Single byte on UART0.
    do_byte(1'b0, 8'hA5, 32'h100);
    chk("single_ptr0", 32'(wrPtr0), 1);

    // CPU contention: UART1 waits while the CPU writes.
    memWriteCPU = 1'b1; readyRx1 = 1'b1; rxData1 = 8'h3C;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("cpu_hold_grant", 32'(busGrant), 0);
    end
    memWriteCPU = 1'b0;
    do_byte(1'b1, 8'h3C, 32'h200);
    chk("cpu_ptr1", 32'(wrPtr1), 1);

    // Round-robin with both UARTs continuously ready.
    do_reset();
    readyRx0 = 1'b1; rxData0 = 8'h10;
    readyRx1 = 1'b1; rxData1 = 8'h20;
    for (int k = 0; k < 4; k++) begin
      logic [31:0] ea;
      logic [7:0]  ed;
      ea = (k % 2 == 0) ? (32'h100 + 32'(k / 2)) : (32'h200 + 32'(k / 2));
      ed = (k % 2 == 0) ? (8'h10 + 8'(k / 2)) : (8'h20 + 8'(k / 2));
      tick();
      chk("rr_grant", 32'(busGrant), 1);
      tick();
      chk("rr_wr", 32'(memWriteOut), 1);
      chk("rr_addr", memAddress, ea);
      chk("rr_data", 32'(memData), 32'(ed));
      chk("rr_ack", {30'd0, ackRx1, ackRx0}, (k % 2 == 0) ? 1 : 2);
      if (k % 2 == 0) rxData0 = rxData0 + 8'd1; else rxData1 = rxData1 + 8'd1;
      tick();
      chk("rr_idle", 32'(busGrant), 0);
    end
    readyRx0 = 1'b0; readyRx1 = 1'b0;

    // Wrap on UART0, then a 17th byte, then clear.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      do_byte(1'b0, 8'(i), 32'h100 + 32'(i));
      if (i == 14) chk("wrap_pre", {27'd0, wrap0, wrPtr0}, 32'h0F);
    end
    chk("wrap_ptr0", 32'(wrPtr0), 0);
    chk("wrap_flag0", 32'(wrap0), 1);
    do_byte(1'b0, 8'h10, 32'h100);
    chk("wrap17", {27'd0, wrap0, wrPtr0}, 32'h11);
    clr0 = 1'b1;
    tick();
    clr0 = 1'b0;
    chk("clr_ptr0", {27'd0, wrap0, wrPtr0}, 0);

    // Clear collision on a WRITE to 0x105; ready/data changes after latching are ignored.
    do_reset();
    for (int i = 0; i < 5; i++) do_byte(1'b0, 8'h50 + 8'(i), 32'h100 + 32'(i));
    do_byte(1'b1, 8'h77, 32'h200);
    readyRx0 = 1'b1; rxData0 = 8'hC3;
    tick();
    chk("col_grant", 32'(busGrant), 1);
    readyRx0 = 1'b0; rxData0 = 8'hFF;
    tick();
    chk("col_wr", 32'(memWriteOut), 1);
    chk("col_addr", memAddress, 32'h105);
    chk("col_data", 32'(memData), 32'hC3);
    chk("col_ack", {30'd0, ackRx1, ackRx0}, 1);
    clr0 = 1'b1;
    tick();
    clr0 = 1'b0;
    chk("col_ptr0", {27'd0, wrap0, wrPtr0}, 0);
    chk("col_ptr1", 32'(wrPtr1), 1);
    chk("col_idle", 32'(busGrant), 0);

    // Reset during GRANT aborts the transfer; the byte is rewritten afterwards.
    do_reset();
    readyRx0 = 1'b1; rxData0 = 8'h5A;
    tick();
    chk("mid_grant", 32'(busGrant), 1);
    reset = 1'b1;
    tick();
    chk("mid_wr", 32'(memWriteOut), 0);
    chk("mid_ack", {30'd0, ackRx1, ackRx0}, 0);
    chk("mid_busg", 32'(busGrant), 0);
    chk("mid_addr", memAddress, 0);
    chk("mid_data", 32'(memData), 0);
    chk("mid_ptr", {27'd0, wrap0, wrPtr0}, 0);
    reset = 1'b0;
    do_byte(1'b0, 8'h5A, 32'h100);
    chk("mid_ptr_after", 32'(wrPtr0), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
